// File: rtl/scan_sequencer.sv
// Scan sequencer for a 2-to-4 decoder: steps the select pair {a,b} through the
// enabled slots, holds each for dwell+1 cycles and blanks e for one cycle between slots.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         mask,
    output logic               a,
    output logic               b,
    output logic               e,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

    state_t             state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [1:0]         idx, idx_n;
    logic [1:0]         low_idx, next_idx;
    logic               wrap_n;

    // The select outputs double as the current slot index.
    assign idx = {a, b};

    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (mask[i]) low_idx = 2'(i);
    end

    // Search upward from idx+1; step 4 lands back on idx (lone enabled slot).
    // Descending loop so the smallest step wins.
    always_comb begin
        next_idx = idx;
        for (int s = 4; s >= 1; s--)
            if (mask[idx + 2'(s)]) next_idx = idx + 2'(s);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        wrap_n  = 1'b0;
        case (state)
            IDLE: begin
                idx_n = 2'd0;
                cnt_n = '0;
                if (start && !stop && (mask != 4'd0)) begin
                    state_n = SCAN;
                    idx_n   = low_idx;
                    cnt_n   = dwell;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_n = IDLE;
                    idx_n   = 2'd0;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = BLANK;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            BLANK: begin
                if (stop || (mask == 4'd0)) begin
                    state_n = IDLE;
                    idx_n   = 2'd0;
                    cnt_n   = '0;
                end else begin
                    state_n = SCAN;
                    idx_n   = next_idx;
                    cnt_n   = dwell;
                    wrap_n  = (next_idx <= idx);
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 2'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so e and {a,b} switch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            e      <= 1'b0;
            busy   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            a      <= idx_n[1];
            b      <= idx_n[0];
            e      <= (state_n == SCAN);
            busy   <= (state_n != IDLE);
            wrap   <= wrap_n;
        end
    end

endmodule
